// File: rtl/apb_requester_arbiter_if.sv
// apb_if: APB port bundle; dst faces a requester, src drives the shared downstream target.
interface apb_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic psel, penable, pwrite, pready, pslverr;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata, prdata;
   modport dst (input psel, penable, pwrite, paddr, pwdata, output pready, prdata, pslverr);
   modport src (output psel, penable, pwrite, paddr, pwdata, input pready, prdata, pslverr);
endinterface

// File: rtl/apb_requester_arbiter.sv
// apb_requester_arbiter: round-robin two-requester APB arbiter onto one target.
// Define APB_ARB_TIMEOUT_EN to add an access-phase watchdog of TIMEOUT_CYCLES.
module apb_requester_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic clk,
   input logic rst_n,
   apb_if.dst apbReq0,
   apb_if.dst apbReq1,
   apb_if.src apbOut
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t state;
   logic last_grant, gnt, pick, psel, penable, pwrite, rdy0, rdy1, pslverr;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata, prdata;
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end
`ifdef APB_ARB_TIMEOUT_EN
   logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cnt;
`endif
   // Contention goes to whoever did not win last time.
   assign pick = apbReq0.psel && apbReq1.psel ? ~last_grant : apbReq1.psel;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last_grant <= 1'b1;
         gnt <= 1'b0;
         psel <= 1'b0;
         penable <= 1'b0;
         pwrite <= 1'b0;
         paddr <= '0;
         pwdata <= '0;
         rdy0 <= 1'b0;
         rdy1 <= 1'b0;
         prdata <= '0;
         pslverr <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (apbReq0.psel || apbReq1.psel) begin
               gnt <= pick;
               last_grant <= pick;
               paddr <= pick ? apbReq1.paddr : apbReq0.paddr;
               pwdata <= pick ? apbReq1.pwdata : apbReq0.pwdata;
               pwrite <= pick ? apbReq1.pwrite : apbReq0.pwrite;
               psel <= 1'b1;
               state <= SETUP;
            end
            SETUP: begin
               penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
               cnt <= '0;
`endif
               state <= ACCESS;
            end
            ACCESS: if (apbOut.pready) begin
               psel <= 1'b0;
               penable <= 1'b0;
               prdata <= apbOut.prdata;
               pslverr <= apbOut.pslverr;
               rdy0 <= ~gnt;
               rdy1 <= gnt;
               state <= RESP;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (cnt + 1'b1 == $bits(cnt)'(TIMEOUT_CYCLES)) begin
               psel <= 1'b0;
               penable <= 1'b0;
               prdata <= '0;
               pslverr <= 1'b1;
               rdy0 <= ~gnt;
               rdy1 <= gnt;
               state <= RESP;
            end else cnt <= cnt + 1'b1;
`endif
            RESP: begin
               rdy0 <= 1'b0;
               rdy1 <= 1'b0;
               prdata <= '0;
               pslverr <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
   assign apbOut.psel = psel;
   assign apbOut.penable = penable;
   assign apbOut.pwrite = pwrite;
   assign apbOut.paddr = paddr;
   assign apbOut.pwdata = pwdata;
   assign apbReq0.pready = rdy0;
   assign apbReq0.prdata = rdy0 ? prdata : '0;
   assign apbReq0.pslverr = rdy0 & pslverr;
   assign apbReq1.pready = rdy1;
   assign apbReq1.prdata = rdy1 ? prdata : '0;
   assign apbReq1.pslverr = rdy1 & pslverr;
endmodule

// File: tb/tb_apb_requester_arbiter.sv
// tb_apb_requester_arbiter: directed checks of grant order, timing, responses and reset.
module tb_apb_requester_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   int tests = 0, fails = 0;
   int wait_states = 0, acc_cnt = 0;
   logic [31:0] tgt_rdata = '0;
   logic tgt_err = 1'b0;
   always #5 clk = ~clk;
   apb_if r0(), r1(), o();
   apb_requester_arbiter #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .apbReq0(r0), .apbReq1(r1), .apbOut(o));
   // Target inserts wait_states wait cycles per access.
   assign o.pready = o.psel && o.penable && acc_cnt == wait_states;
   assign o.prdata = o.pready ? tgt_rdata : '0;
   assign o.pslverr = o.pready && tgt_err;
   always @(posedge clk) acc_cnt <= (o.psel && o.penable && !o.pready) ? acc_cnt + 1 : 0;
   always @(negedge clk) if (rst_n) begin
      tests++;
      if (o.penable && !o.psel) begin fails++; $display("FAIL penable_without_psel got penable=1 psel=0 want psel=1"); end
   end

   task idle_reqs;
      r0.psel = 0; r0.penable = 0; r0.pwrite = 0; r0.paddr = '0; r0.pwdata = '0;
      r1.psel = 0; r1.penable = 0; r1.pwrite = 0; r1.paddr = '0; r1.pwdata = '0;
   endtask

   task test_reset;
      rst_n = 0; idle_reqs();
      repeat (2) @(negedge clk);
      tests++; if ({o.psel, o.penable, o.pwrite} !== 3'b000) begin fails++; $display("FAIL rst_ctl got %b want 000", {o.psel, o.penable, o.pwrite}); end
      tests++; if ({o.paddr, o.pwdata} !== 64'h0) begin fails++; $display("FAIL rst_addr_data got %h want 0", {o.paddr, o.pwdata}); end
      tests++; if ({r0.pready, r0.pslverr, r1.pready, r1.pslverr} !== 4'b0) begin fails++; $display("FAIL rst_rsp got %b want 0000", {r0.pready, r0.pslverr, r1.pready, r1.pslverr}); end
      tests++; if ({r0.prdata, r1.prdata} !== 64'h0) begin fails++; $display("FAIL rst_prdata got %h want 0", {r0.prdata, r1.prdata}); end
      rst_n = 1; @(negedge clk);
   endtask

   task test_single_write;
      r0.psel = 1; r0.pwrite = 1; r0.paddr = 32'h0000_0010; r0.pwdata = 32'hA5A5_0001; wait_states = 0;
      @(negedge clk);
      tests++; if ({o.psel, o.penable, o.pwrite} !== 3'b101) begin fails++; $display("FAIL w_setup got %b want 101", {o.psel, o.penable, o.pwrite}); end
      tests++; if (o.paddr !== 32'h10 || o.pwdata !== 32'hA5A5_0001) begin fails++; $display("FAIL w_addr_data got %h/%h want 00000010/a5a50001", o.paddr, o.pwdata); end
      @(negedge clk);
      tests++; if ({o.psel, o.penable} !== 2'b11) begin fails++; $display("FAIL w_access got %b want 11", {o.psel, o.penable}); end
      @(negedge clk);
      tests++; if ({r0.pready, r1.pready, o.psel} !== 3'b100) begin fails++; $display("FAIL w_resp got %b want 100", {r0.pready, r1.pready, o.psel}); end
      r0.psel = 0;
      @(negedge clk);
      tests++; if ({r0.pready, o.psel} !== 2'b00) begin fails++; $display("FAIL w_after got %b want 00", {r0.pready, o.psel}); end
   endtask

   task test_contention;
      rst_n = 0; @(negedge clk); rst_n = 1;
      r0.psel = 1; r0.pwrite = 0; r0.paddr = 32'h0100_0004;
      r1.psel = 1; r1.pwrite = 0; r1.paddr = 32'h0000_0008;
      tgt_rdata = 32'h1234_5678; tgt_err = 0;
      @(negedge clk);
      tests++; if (o.paddr !== 32'h0100_0004 || o.pwrite !== 1'b0) begin fails++; $display("FAIL c_first got %h/%b want 01000004/0", o.paddr, o.pwrite); end
      repeat (2) @(negedge clk);
      tests++; if ({r0.pready, r1.pready} !== 2'b10) begin fails++; $display("FAIL c_r0_rdy got %b want 10", {r0.pready, r1.pready}); end
      tests++; if (r0.prdata !== 32'h1234_5678 || r1.prdata !== 32'h0) begin fails++; $display("FAIL c_r0_data got %h/%h want 12345678/0", r0.prdata, r1.prdata); end
      r0.psel = 0;
      @(negedge clk);
      tests++; if (o.psel !== 1'b0) begin fails++; $display("FAIL c_idle got %b want 0", o.psel); end
      @(negedge clk);
      tests++; if (o.psel !== 1'b1 || o.paddr !== 32'h8) begin fails++; $display("FAIL c_second got %b/%h want 1/00000008", o.psel, o.paddr); end
      tgt_rdata = 32'h0000_0808;
      repeat (2) @(negedge clk);
      tests++; if ({r0.pready, r1.pready} !== 2'b01 || r1.prdata !== 32'h808) begin fails++; $display("FAIL c_r1_rsp got %b/%h want 01/00000808", {r0.pready, r1.pready}, r1.prdata); end
      r1.psel = 0;
      @(negedge clk);
   endtask

   task test_back_to_back;
      int n;
      int seq [8];
      n = 0;
      r0.psel = 1; r0.paddr = 32'h20; r1.psel = 1; r1.paddr = 32'h30;
      for (int c = 0; c < 60 && n < 8; c++) begin
         @(negedge clk);
         if (r0.pready) seq[n++] = 0;
         else if (r1.pready) seq[n++] = 1;
      end
      r0.psel = 0; r1.psel = 0;
      tests++; if (n !== 8) begin fails++; $display("FAIL b2b_count got %0d want 8", n); end
      for (int i = 0; i < n; i++) begin
         tests++; if (seq[i] !== i % 2) begin fails++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, seq[i], i % 2); end
      end
      @(negedge clk);
   endtask

   task test_wait_states;
      int acc;
      bit seen;
      acc = 0; seen = 0;
      r1.psel = 1; r1.pwrite = 0; r1.paddr = 32'h44; wait_states = 3; tgt_rdata = 32'hDEAD_BEEF; tgt_err = 1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (o.psel && o.penable) acc++;
         seen = o.pready;
      end
      tests++; if (!seen) begin fails++; $display("FAIL ws_pready got 0 want 1 within 20 cycles"); end
      tests++; if (acc !== 4 || o.paddr !== 32'h44) begin fails++; $display("FAIL ws_access got %0d/%h want 4/00000044", acc, o.paddr); end
      @(negedge clk);
      tests++; if ({r1.pready, r1.pslverr, r0.pready, r0.pslverr} !== 4'b1100) begin fails++; $display("FAIL ws_rsp got %b want 1100", {r1.pready, r1.pslverr, r0.pready, r0.pslverr}); end
      tests++; if (r1.prdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ws_data got %h want deadbeef", r1.prdata); end
      r1.psel = 0; wait_states = 0; tgt_err = 0;
      @(negedge clk);
   endtask

   task test_reset_mid_access;
      r0.psel = 1; r0.pwrite = 1; r0.paddr = 32'h80; wait_states = 1000;
      repeat (2) @(negedge clk);
      tests++; if ({o.psel, o.penable} !== 2'b11) begin fails++; $display("FAIL rm_access got %b want 11", {o.psel, o.penable}); end
      #2 rst_n = 0;
      #1;
      tests++; if ({o.psel, o.penable, r0.pready} !== 3'b000) begin fails++; $display("FAIL rm_async got %b want 000", {o.psel, o.penable, r0.pready}); end
      @(negedge clk);
      rst_n = 1; wait_states = 0;
      r0.paddr = 32'h90; r1.psel = 1; r1.paddr = 32'hA0;
      @(negedge clk);
      tests++; if (o.paddr !== 32'h90) begin fails++; $display("FAIL rm_first_grant got %h want 00000090", o.paddr); end
      repeat (2) @(negedge clk);
      tests++; if ({r0.pready, r1.pready} !== 2'b10) begin fails++; $display("FAIL rm_rsp got %b want 10", {r0.pready, r1.pready}); end
      r0.psel = 0; r1.psel = 0;
      repeat (2) @(negedge clk);
   endtask

`ifdef APB_ARB_TIMEOUT_EN
   task test_timeout;
      int acc;
      bit seen;
      acc = 0; seen = 0;
      r0.psel = 1; r0.paddr = 32'hC0; wait_states = 1000; tgt_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (o.psel && o.penable) acc++;
         seen = r0.pready;
      end
      tests++; if (!seen || acc !== 16) begin fails++; $display("FAIL to_access got seen=%b acc=%0d want 1/16", seen, acc); end
      tests++; if ({r0.pslverr, o.psel} !== 2'b10 || r0.prdata !== 32'h0) begin fails++; $display("FAIL to_rsp got %b/%h want 10/0", {r0.pslverr, o.psel}, r0.prdata); end
      r0.psel = 0; wait_states = 0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_back_to_back();
      test_wait_states();
      test_reset_mid_access();
`ifdef APB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
